watch_time_counter: RTL and testbench
=====================================

# watch_time_counter

Time-keeping stage of the digital watch: divides the system clock into a 1 Hz tick and keeps a 24-hour BCD HH:MM:SS count. It sits directly upstream of the LCD string formatter and drives its six digit inputs, `hour_10`, `hour1`, `min_10`, `min1`, `sec_10` and `sec1`. A set mode with hour/minute increment inputs lets the user adjust the time.

## Interface
- `CLK_DIV`, default 50_000_000: system-clock cycles per 1 Hz tick; must be ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset: synchronous, active-low; the top level drives it with the inverted board reset.
- `set_mode`  input  1  level input; 1 = time-set mode (count frozen), 0 = run.
- `inc_hour`  input  1  level input, already synchronised and debounced; each rising edge advances the hour.
- `inc_min`  input  1  level input, already synchronised and debounced; each rising edge advances the minute.
- `hour_10`  output  4  tens-of-hours digit, BCD 0–2.
- `hour1`  output  4  units-of-hours digit, BCD 0–9.
- `min_10`  output  4  tens-of-minutes digit, BCD 0–5.
- `min1`  output  4  units-of-minutes digit, BCD 0–9.
- `sec_10`  output  4  tens-of-seconds digit, BCD 0–5.
- `sec1`  output  4  units-of-seconds digit, BCD 0–9.
- `tick_1hz`  output  1  one-cycle pulse marking a seconds advance.
- `day_wrap`  output  1  one-cycle pulse marking the 23:59:59 → 00:00:00 rollover.

## Operation
- **Prescaler.**
  - Counter `pre`, width `$clog2(CLK_DIV)`.
  - In run mode `pre` counts 0..`CLK_DIV`−1 and wraps to 0.
  - The terminal cycle (`pre` == `CLK_DIV`−1) is the advance cycle.
- **Seconds advance (run mode, advance cycle).**
  - `sec1` increments.
  - 9 → 0 carries into `sec_10`; `sec_10` 5 → 0 carries into minutes.
- **Minutes.** `min1` 9 → 0 carries into `min_10`; `min_10` 5 → 0 carries into hours.
- **Hours.**
  - `hour1` 9 → 0 increments `hour_10`.
  - Hours 23 → 00 clears both hour digits and pulses `day_wrap`.
- **No invalid codes.** Digits never hold a value outside their range listed above; bits above the range are always 0.
- **Set-mode entry.** When `set_mode` goes 0 → 1, at that edge:
  - `pre` clears to 0;
  - `sec_10` and `sec1` clear to 0.
- **While `set_mode` = 1.**
  - `pre` is held at 0; no `tick_1hz`, no seconds advance.
- **Increments in set mode.**
  - Edge detection: registered copies `inc_hour_d` and `inc_min_d`; an edge is `inc_x & ~inc_x_d`.
  - Hour edge: hours advance by 1 (modulo 24, 23 → 00). No `day_wrap` is produced.
  - Minute edge: minutes advance by 1 (modulo 60, 59 → 00). No carry into hours.
  - Both edges in the same cycle: both applied independently.
- **Increments in run mode.** Edges are ignored; the `_d` registers still update every cycle.
- **Set-mode exit.** When `set_mode` goes 1 → 0, counting resumes. The first tick occurs `CLK_DIV` cycles after the first run-mode cycle.
- **Reset** (`rst` = 0 at a clock edge) overrides everything, including mid-carry and set mode. After reset:
  - all digits = 0;
  - `pre` = 0;
  - `tick_1hz` = 0, `day_wrap` = 0;
  - `inc_hour_d` = 0, `inc_min_d` = 0;
  - set-mode history register = 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Seconds advance.** On the clock edge that ends an advance cycle:
  - the new digit values appear;
  - `tick_1hz` rises and stays high exactly one cycle.
- **Day rollover.** `day_wrap` is high in the same cycle that `tick_1hz` is high and the digits show 00:00:00.
- **Tick spacing.** In uninterrupted run mode, consecutive `tick_1hz` pulses are exactly `CLK_DIV` cycles apart.
- **Increment latency.** With `inc_min` sampled 1 at edge N and 0 at edge N−1, the updated minute is visible after edge N. Latency is one cycle.
- **Held inputs.** An increment input held high produces exactly one increment.
- **Reset latency.** Outputs read reset values from the first edge at which `rst` = 0 is sampled.

## Test plan
- **Reset.** `CLK_DIV`=4; hold `rst`=0 for 3 cycles, then release.
  - All digits 0, `tick_1hz`=0, `day_wrap`=0 during reset.
  - First `tick_1hz` 4 cycles after release, showing 00:00:01.
- **Seconds and minutes carry.** `CLK_DIV`=4; load 00:00:59 via set mode plus 59 ticks.
  - Next tick shows 00:01:00.
  - Ticks are spaced exactly 4 cycles.
- **Day rollover.** Set 23:59 and run to :59.
  - Next tick shows 00:00:00 with `tick_1hz`=1 and `day_wrap`=1 in the same cycle.
  - `day_wrap` is 0 on the following cycle.
- **Set-mode increments.**
  - Enter `set_mode` at 12:34:27: seconds show 00 next cycle.
  - Pulse `inc_min` 26 times from :34: minutes show 00 and hours stay 12.
  - Pulse `inc_hour` 12 times: hours show 00 and `day_wrap` stays 0.
  - Hold `inc_hour` high 10 cycles: exactly one increment.
  - Drive both inputs' rising edges in the same cycle: both fields increment.
- **Run-mode increments ignored.** Pulse `inc_hour` and `inc_min` while `set_mode`=0.
  - Time is unchanged apart from normal ticks.
- **Reset mid-operation.** Assert `rst`=0 on the advance cycle at 09:59:59.
  - Outputs show 00:00:00 and `tick_1hz`=0.
  - No 10:00:00 value ever appears.

Source files
------------

// File: rtl/watch_time_counter.sv
// watch_time_counter
//   Time-keeping stage of the digital watch. A prescaler divides clk into a
//   1 Hz advance, and a 24-hour BCD HH:MM:SS count feeds the LCD formatter.
//   Set mode freezes the count, clears the seconds on entry, and lets rising
//   edges on inc_hour / inc_min step the hour and minute fields.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   set_mode   1 = time-set mode (count frozen), 0 = run
//   inc_hour   level, debounced; each rising edge in set mode adds one hour
//   inc_min    level, debounced; each rising edge in set mode adds one minute
//   hour_10/hour1/min_10/min1/sec_10/sec1   BCD digits, registered
//   tick_1hz   one-cycle pulse with each seconds advance
//   day_wrap   one-cycle pulse with the 23:59:59 -> 00:00:00 rollover
module watch_time_counter #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic [3:0] hour_10,
  output logic [3:0] hour1,
  output logic [3:0] min_10,
  output logic [3:0] min1,
  output logic [3:0] sec_10,
  output logic [3:0] sec1,
  output logic       tick_1hz,
  output logic       day_wrap
);

  localparam int              PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    hr10_q, hr10_d, hr1_q, hr1_d;
  logic [3:0]    mn10_q, mn10_d, mn1_q, mn1_d;
  logic [3:0]    sc10_q, sc10_d, sc1_q, sc1_d;
  logic          tick_q, tick_d, wrap_q, wrap_d;
  // Registered copies of the increment inputs and of set_mode for edge detection.
  logic          inc_hour_dq, inc_hour_dd, inc_min_dq, inc_min_dd;
  logic          set_mode_q, set_mode_d;

  // Next-value of the minute and hour fields, shared by the run-mode carry
  // chain and the set-mode increments so both wrap identically.
  logic [3:0] mn10_n, mn1_n, hr10_n, hr1_n;
  logic       mn_wrap, hr_wrap;
  logic       hour_edge, min_edge;

  always_comb begin
    mn1_n   = mn1_q + 4'd1;
    mn10_n  = mn10_q;
    mn_wrap = 1'b0;
    if (mn1_q == 4'd9) begin
      mn1_n = 4'd0;
      if (mn10_q == 4'd5) begin
        mn10_n  = 4'd0;
        mn_wrap = 1'b1;
      end else begin
        mn10_n = mn10_q + 4'd1;
      end
    end

    hr1_n   = hr1_q + 4'd1;
    hr10_n  = hr10_q;
    hr_wrap = 1'b0;
    if (hr10_q == 4'd2 && hr1_q == 4'd3) begin
      hr1_n   = 4'd0;
      hr10_n  = 4'd0;
      hr_wrap = 1'b1;
    end else if (hr1_q == 4'd9) begin
      hr1_n  = 4'd0;
      hr10_n = hr10_q + 4'd1;
    end
  end

  assign hour_edge = inc_hour & ~inc_hour_dq;
  assign min_edge  = inc_min  & ~inc_min_dq;

  always_comb begin
    pre_d       = pre_q;
    hr10_d      = hr10_q;
    hr1_d       = hr1_q;
    mn10_d      = mn10_q;
    mn1_d       = mn1_q;
    sc10_d      = sc10_q;
    sc1_d       = sc1_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    inc_hour_dd = inc_hour;
    inc_min_dd  = inc_min;
    set_mode_d  = set_mode;

    if (set_mode) begin
      // Prescaler parked at 0 so the first tick after exit is a full period away.
      pre_d = '0;
      if (!set_mode_q) begin
        sc10_d = 4'd0;
        sc1_d  = 4'd0;
      end
      // Field-local wraps only: minutes never carry into hours here and an
      // hour wrap is not a day rollover.
      if (min_edge) begin
        mn10_d = mn10_n;
        mn1_d  = mn1_n;
      end
      if (hour_edge) begin
        hr10_d = hr10_n;
        hr1_d  = hr1_n;
      end
    end else if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      tick_d = 1'b1;
      if (sc1_q != 4'd9) begin
        sc1_d = sc1_q + 4'd1;
      end else begin
        sc1_d = 4'd0;
        if (sc10_q != 4'd5) begin
          sc10_d = sc10_q + 4'd1;
        end else begin
          sc10_d = 4'd0;
          mn10_d = mn10_n;
          mn1_d  = mn1_n;
          if (mn_wrap) begin
            hr10_d = hr10_n;
            hr1_d  = hr1_n;
            wrap_d = hr_wrap;
          end
        end
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q       <= '0;
      hr10_q      <= 4'd0;
      hr1_q       <= 4'd0;
      mn10_q      <= 4'd0;
      mn1_q       <= 4'd0;
      sc10_q      <= 4'd0;
      sc1_q       <= 4'd0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      inc_hour_dq <= 1'b0;
      inc_min_dq  <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      hr10_q      <= hr10_d;
      hr1_q       <= hr1_d;
      mn10_q      <= mn10_d;
      mn1_q       <= mn1_d;
      sc10_q      <= sc10_d;
      sc1_q       <= sc1_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      inc_hour_dq <= inc_hour_dd;
      inc_min_dq  <= inc_min_dd;
      set_mode_q  <= set_mode_d;
    end
  end

  assign hour_10  = hr10_q;
  assign hour1    = hr1_q;
  assign min_10   = mn10_q;
  assign min1     = mn1_q;
  assign sec_10   = sc10_q;
  assign sec1     = sc1_q;
  assign tick_1hz = tick_q;
  assign day_wrap = wrap_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter with CLK_DIV = 4. Inputs are driven
// and outputs sampled on the falling edge; time is compared as packed BCD
// {hour_10,hour1,min_10,min1,sec_10,sec1}.
module tb_watch_time_counter;

  localparam int DIV = 4;

  logic       clk, rst, set_mode, inc_hour, inc_min;
  logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;
  logic       tick_1hz, day_wrap;

  int checks = 0;
  int errors = 0;
  bit wrap_seen, tick_seen, seen_ten;

  watch_time_counter #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .inc_hour(inc_hour), .inc_min(inc_min),
    .hour_10(hour_10), .hour1(hour1), .min_10(min_10), .min1(min1),
    .sec_10(sec_10), .sec1(sec1), .tick_1hz(tick_1hz), .day_wrap(day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [23:0] tm = {hour_10, hour1, min_10, min1, sec_10, sec1};

  always @(negedge clk) begin
    if (day_wrap)          wrap_seen = 1'b1;
    if (tick_1hz)          tick_seen = 1'b1;
    if (tm == 24'h100000)  seen_ten  = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Waits up to max falling edges for tick_1hz; n = edges waited.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_1hz && n < max);
    if (!tick_1hz) chk("tick_timeout", 32'(n), 32'(max + 1));
  endtask

  task automatic run_ticks(input int cnt, output int total);
    int n;
    total = 0;
    repeat (cnt) begin
      wait_tick(2 * DIV, n);
      total += n;
    end
  endtask

  // n single-cycle pulses separated by one low cycle.
  task automatic pulse(input bit h, input bit m, input int n);
    repeat (n) begin
      inc_hour = h;
      inc_min  = m;
      @(negedge clk);
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, total;
    rst = 1'b0; set_mode = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;

    // Reset and first tick
    repeat (3) @(negedge clk);
    chk("rst_time", tm, 24'h000000);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_wrap", day_wrap, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_tick_3", tick_1hz, 0);
    @(negedge clk);
    chk("first_tick", tick_1hz, 1);
    chk("first_time", tm, 24'h000001);

    // Seconds -> minutes carry, tick spacing
    run_ticks(58, total);
    chk("spacing_58", total, 58 * DIV);
    chk("time_0059", tm, 24'h000059);
    wait_tick(2 * DIV, n);
    chk("spacing_carry", n, DIV);
    chk("time_0100", tm, 24'h000100);

    // Build 12:34:27
    set_mode = 1'b1;
    @(negedge clk);
    pulse(1, 0, 12);
    pulse(0, 1, 33);
    chk("set_1234", tm, 24'h123400);
    set_mode = 1'b0;
    run_ticks(27, total);
    chk("time_123427", tm, 24'h123427);

    // Set-mode entry clears seconds next cycle
    set_mode = 1'b1;
    @(negedge clk);
    chk("entry_clr", tm, 24'h123400);
    tick_seen = 1'b0;
    wrap_seen = 1'b0;
    inc_min = 1'b1;
    @(negedge clk);
    chk("min_latency", tm, 24'h123500);
    inc_min = 1'b0;
    @(negedge clk);
    pulse(0, 1, 25);
    chk("min_wrap", tm, 24'h120000);
    pulse(1, 0, 12);
    chk("hour_wrap", tm, 24'h000000);
    chk("set_no_wrap", wrap_seen, 0);
    inc_hour = 1'b1;
    repeat (10) @(negedge clk);
    inc_hour = 1'b0;
    @(negedge clk);
    chk("held_once", tm, 24'h010000);
    inc_hour = 1'b1; inc_min = 1'b1;
    @(negedge clk);
    chk("both_edges", tm, 24'h020100);
    inc_hour = 1'b0; inc_min = 1'b0;
    @(negedge clk);
    chk("set_no_tick", tick_seen, 0);

    // Run mode ignores increments; first tick DIV cycles after exit
    set_mode = 1'b0;
    inc_hour = 1'b1; inc_min = 1'b1;
    @(negedge clk);
    inc_hour = 1'b0; inc_min = 1'b0;
    @(negedge clk);
    chk("run_ignore", tm, 24'h020100);
    wait_tick(2 * DIV, n);
    chk("exit_latency", n, DIV - 2);
    chk("run_tick_time", tm, 24'h020101);

    // Day rollover
    set_mode = 1'b1;
    @(negedge clk);
    pulse(1, 0, 21);
    pulse(0, 1, 58);
    chk("set_2359", tm, 24'h235900);
    set_mode = 1'b0;
    run_ticks(59, total);
    chk("time_235959", tm, 24'h235959);
    wait_tick(2 * DIV, n);
    chk("wrap_time", tm, 24'h000000);
    chk("wrap_tick", tick_1hz, 1);
    chk("wrap_pulse", day_wrap, 1);
    @(negedge clk);
    chk("wrap_drop", day_wrap, 0);
    chk("tick_drop", tick_1hz, 0);

    // Reset on the advance cycle at 09:59:59
    set_mode = 1'b1;
    @(negedge clk);
    pulse(1, 0, 9);
    pulse(0, 1, 59);
    set_mode = 1'b0;
    run_ticks(59, total);
    chk("time_095959", tm, 24'h095959);
    seen_ten = 1'b0;
    repeat (DIV - 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_time", tm, 24'h000000);
    chk("midrst_tick", tick_1hz, 0);
    rst = 1'b1;
    wait_tick(2 * DIV, n);
    chk("post_rst_lat", n, DIV);
    chk("post_rst_time", tm, 24'h000001);
    chk("no_1000", seen_ten, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
